// File: rtl/mac_int_pkg.sv
`default_nettype none
// ============================================================================
// mac_int_pkg : shared helpers for the multi-lane integer MAC
//               (saturating add, lane slicing, parameter legality)
// Revision    : 1.0
// ============================================================================
package mac_int_pkg;

   localparam int c_max_acc_w = 63;

   typedef struct packed {
      logic        sat;
      logic [63:0] val;
   } sat_res_t;

   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

   function automatic int acc_w_min(input int a_w, input int b_w, input int lanes);
      return a_w + b_w + $clog2(lanes);
   endfunction

   function automatic bit params_ok(input int acc_w, input int a_w, input int b_w,
                                    input int lanes);
      return (acc_w >= acc_w_min(a_w, b_w, lanes)) && (acc_w <= c_max_acc_w) &&
             (lanes >= 1) && (lanes <= 16) && ((lanes & (lanes - 1)) == 0);
   endfunction

   // Operands are w-bit patterns; they are re-extended here so the 65-bit sum never wraps.
   function automatic sat_res_t sat_add(input logic [63:0] a, input logic [63:0] b,
                                        input int unsigned w, input logic sgn);
      logic [64:0] mask;
      logic [64:0] sbit;
      logic [64:0] ea;
      logic [64:0] eb;
      logic [64:0] sum;
      logic [64:0] hi;
      logic [64:0] lo;
      sat_res_t    r;
      mask  = (65'd1 << w) - 65'd1;
      sbit  = mask ^ (mask >> 1);
      ea    = {1'b0, a} & mask;
      eb    = {1'b0, b} & mask;
      r.sat = 1'b0;
      if (sgn) begin
         if ((ea & sbit) != '0) ea = ea | ~mask;
         if ((eb & sbit) != '0) eb = eb | ~mask;
         hi  = mask >> 1;
         lo  = ~hi;
         sum = ea + eb;
         if ($signed(sum) > $signed(hi)) begin
            sum   = hi;
            r.sat = 1'b1;
         end else if ($signed(sum) < $signed(lo)) begin
            sum   = lo;
            r.sat = 1'b1;
         end
      end else begin
         sum = ea + eb;
         if (sum > mask) begin
            sum   = mask;
            r.sat = 1'b1;
         end
      end
      r.val = sum[63:0] & mask[63:0];
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mac_int_lane_tree.sv
`default_nettype none
// ============================================================================
// mac_int_lane_tree : LANES parallel multipliers with registered products
//                     feeding the reduction tree
// Revision          : 1.0
// ============================================================================
module mac_int_lane_tree
   import mac_int_pkg::*;
#(
   parameter int LANES = 4,
   parameter int A_W   = 9,
   parameter int B_W   = 9,
   parameter int ACC_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_en,
   input  logic [LANES*A_W-1:0]   i_a,
   input  logic [LANES*B_W-1:0]   i_b,
   input  logic                   i_signed,
   output logic                   o_signed,
   output logic [ACC_W-1:0]       o_sum
);

   localparam int c_p_w = A_W + B_W;

   logic [LANES*c_p_w-1:0] w_prod;
   logic [LANES*c_p_w-1:0] r_prod;
   logic [ACC_W-1:0]       w_ext [LANES];
   logic                   r_signed;

   // Operands are pre-extended to the product width so a plain multiply gives the
   // correct low bits in both modes.
   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         logic [c_p_w-1:0] w_a;
         logic [c_p_w-1:0] w_b;
         assign w_a = {{B_W{i_signed & i_a[lane_lsb(i, A_W) + A_W - 1]}},
                       i_a[lane_lsb(i, A_W) +: A_W]};
         assign w_b = {{A_W{i_signed & i_b[lane_lsb(i, B_W) + B_W - 1]}},
                       i_b[lane_lsb(i, B_W) +: B_W]};
         assign w_prod[lane_lsb(i, c_p_w) +: c_p_w] = w_a * w_b;
         assign w_ext[i] = {{(ACC_W - c_p_w){r_signed & r_prod[lane_lsb(i, c_p_w) + c_p_w - 1]}},
                            r_prod[lane_lsb(i, c_p_w) +: c_p_w]};
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_prod   <= '0;
         r_signed <= 1'b0;
      end else if (i_en) begin
         r_prod   <= w_prod;
         r_signed <= i_signed;
      end
   end

   always_comb begin
      o_sum = '0;
      for (int k = 0; k < LANES; k++) begin
         o_sum = o_sum + w_ext[k];
      end
   end

   assign o_signed = r_signed;

endmodule
`default_nettype wire

// File: rtl/mac_int_vec.sv
`default_nettype none
// ============================================================================
// mac_int_vec : multi-lane streamed dot-product MAC with saturating
//               accumulation, handshakes on both sides and beat counting
// Revision    : 1.0
// ============================================================================
module mac_int_vec
   import mac_int_pkg::*;
#(
   parameter int LANES = 4,
   parameter int A_W   = 9,
   parameter int B_W   = 9,
   parameter int ACC_W = 32,
   parameter int CNT_W = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*A_W-1:0]   in_a,
   input  logic [LANES*B_W-1:0]   in_b,
   input  logic                   in_last,
   input  logic                   in_signed,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [ACC_W-1:0]       out_result,
   output logic                   out_sat,
   output logic [CNT_W-1:0]       out_beats
);

   localparam bit c_params_ok = params_ok(ACC_W, A_W, B_W, LANES);

   generate
      if (!c_params_ok) begin : g_param_check
         $error("mac_int_vec: need ACC_W >= A_W+B_W+log2(LANES), ACC_W <= 63, LANES power of two in 1..16");
      end
   endgenerate

   logic                 w_stall;
   logic                 r_s1_valid;
   logic                 r_s1_last;
   logic                 r_s1_signed;
   logic [LANES*A_W-1:0] r_s1_a;
   logic [LANES*B_W-1:0] r_s1_b;
   logic                 r_s2_valid;
   logic                 r_s2_last;
   logic                 w_s2_signed;
   logic [ACC_W-1:0]     w_s2_sum;
   logic [ACC_W-1:0]     r_acc;
   logic                 r_acc_sat;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_first;
   logic                 r_out_valid;
   logic [ACC_W-1:0]     r_out_result;
   logic                 r_out_sat;
   logic [CNT_W-1:0]     r_out_beats;
   sat_res_t             w_add;
   logic [ACC_W-1:0]     w_acc_base;
   logic [ACC_W-1:0]     w_acc_next;
   logic                 w_sat_next;
   logic [CNT_W-1:0]     w_cnt_next;
   logic                 w_unused_hi;

   // A pending result that the consumer has not taken freezes the whole pipe.
   assign w_stall  = r_out_valid & ~out_ready;
   assign in_ready = reset & ~w_stall;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_last   <= 1'b0;
         r_s1_signed <= 1'b0;
         r_s1_a      <= '0;
         r_s1_b      <= '0;
         r_s2_valid  <= 1'b0;
         r_s2_last   <= 1'b0;
      end else if (!w_stall) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_last   <= in_last;
            r_s1_signed <= in_signed;
            r_s1_a      <= in_a;
            r_s1_b      <= in_b;
         end
         r_s2_valid <= r_s1_valid;
         r_s2_last  <= r_s1_last;
      end
   end

   mac_int_lane_tree #(
      .LANES (LANES),
      .A_W   (A_W),
      .B_W   (B_W),
      .ACC_W (ACC_W)
   ) u_lane_tree (
      .clk      (clk),
      .reset    (reset),
      .i_en     (~w_stall),
      .i_a      (r_s1_a),
      .i_b      (r_s1_b),
      .i_signed (r_s1_signed),
      .o_signed (w_s2_signed),
      .o_sum    (w_s2_sum)
   );

   always_comb begin
      w_acc_base = r_first ? '0 : r_acc;
      w_add      = sat_add(64'(w_acc_base), 64'(w_s2_sum), ACC_W, w_s2_signed);
      w_acc_next = w_add.val[ACC_W-1:0];
      w_sat_next = w_add.sat | (~r_first & r_acc_sat);
      if (r_first) begin
         w_cnt_next = CNT_W'(1);
      end else if (&r_cnt) begin
         w_cnt_next = r_cnt;
      end else begin
         w_cnt_next = r_cnt + CNT_W'(1);
      end
   end

   assign w_unused_hi = ^w_add.val[63:ACC_W];

   // Loading a new result wins over clearing the one just consumed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_acc        <= '0;
         r_acc_sat    <= 1'b0;
         r_cnt        <= '0;
         r_first      <= 1'b1;
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_sat    <= 1'b0;
         r_out_beats  <= '0;
      end else begin
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (!w_stall && r_s2_valid) begin
            r_acc     <= w_acc_next;
            r_acc_sat <= w_sat_next;
            r_cnt     <= w_cnt_next;
            r_first   <= r_s2_last;
            if (r_s2_last) begin
               r_out_valid  <= 1'b1;
               r_out_result <= w_acc_next;
               r_out_sat    <= w_sat_next;
               r_out_beats  <= w_cnt_next;
            end
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_sat    = r_out_sat;
   assign out_beats  = r_out_beats;

endmodule
`default_nettype wire
